// File: rtl/adder_tree_pkg.sv
// Shared constants and types for the adder tree and its stream feeder.
// The feeder packs operands into tree-width groups and tracks results by tag.
package adder_tree_pkg;
  localparam int OPERANDS = 8;
  localparam int OP_W     = 16;
  localparam int SUM_W    = 32;
  localparam int CNT_W    = 4;
  localparam int TREE_LAT = 3;
  localparam int IDX_W    = $clog2(OPERANDS);

  typedef enum logic {
    FILL  = 1'b0,
    ISSUE = 1'b1
  } feed_state_t;

  typedef struct packed {
    logic             valid;
    logic [CNT_W-1:0] count;
  } tag_t;

  typedef logic [OPERANDS-1:0][OP_W-1:0] ops_t;
endpackage

// File: rtl/adder_tree.sv
// 8-input, 3-stage pipelined 16-bit adder tree.
// Free-running, unstallable and unreset; sum_out is zero-extended.
module adder_tree
  import adder_tree_pkg::*;
(
  input  logic             clk,
  input  ops_t             in_ops,
  output logic [SUM_W-1:0] sum_out
);
  logic [OP_W:0]   r_s1 [4];
  logic [OP_W+1:0] r_s2 [2];
  logic [OP_W+2:0] r_s3;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      r_s1[i] <= {1'b0, in_ops[2*i]} + {1'b0, in_ops[2*i+1]};
    for (int i = 0; i < 2; i++)
      r_s2[i] <= {1'b0, r_s1[2*i]} + {1'b0, r_s1[2*i+1]};
    r_s3 <= {1'b0, r_s2[0]} + {1'b0, r_s2[1]};
  end

  assign sum_out = {{(SUM_W-OP_W-3){1'b0}}, r_s3};
endmodule

// File: rtl/adder_tree_result_fifo.sv
// Synchronous result FIFO whose head is held in an output register.
// The head register is only reloaded when an entry remains, so it is stable.
module adder_tree_result_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 36
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         valid
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_dout;
  logic          r_valid;

  logic          w_pop;
  logic [PW-1:0] w_rptr_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [W-1:0]  w_head;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign w_pop      = pop && r_valid;
  assign w_rptr_nxt = w_pop ? inc(r_rptr) : r_rptr;
  assign w_cnt_nxt  = r_count + CW'(push) - CW'(w_pop);
  // a push into the slot that becomes the head bypasses the array
  assign w_head     = (push && r_wptr == w_rptr_nxt) ? din
                                                     : r_mem[w_rptr_nxt];

  always_ff @(posedge clk) begin
    if (push)
      r_mem[r_wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else begin
      if (push)
        r_wptr <= inc(r_wptr);
      r_rptr  <= w_rptr_nxt;
      r_count <= w_cnt_nxt;
      r_valid <= (w_cnt_nxt != '0);
      if (w_cnt_nxt != '0)
        r_dout <= w_head;
    end
  end

  assign dout  = r_dout;
  assign valid = r_valid;
endmodule

// File: rtl/adder_tree_stream_feeder.sv
// Packs a serial operand stream into adder tree groups and returns
// {sum, count} results; credits keep the result FIFO from overflowing.
module adder_tree_stream_feeder
  import adder_tree_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count
);
  localparam int CRW = $clog2(DEPTH + 1);

  feed_state_t      r_state;
  feed_state_t      w_state_nxt;
  logic [IDX_W-1:0] r_idx;
  ops_t             r_slots;
  logic [CNT_W-1:0] r_count;
  logic [CRW-1:0]   r_credits;
  tag_t             r_tag [TREE_LAT];

  logic             w_accept;
  logic             w_end;
  logic             w_issue;
  logic             w_pop;
  logic [SUM_W-1:0] w_sum;

  assign w_accept = in_valid && in_ready;
  assign w_end    = w_accept &&
                    (in_last || r_idx == IDX_W'(OPERANDS-1));
  assign w_pop    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= FILL;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      FILL:  if (w_end)   w_state_nxt = ISSUE;
      ISSUE: if (w_issue) w_state_nxt = FILL;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    w_issue  = 1'b0;
    unique case (r_state)
      FILL:  in_ready = 1'b1;
      ISSUE: w_issue  = (r_credits != '0);
    endcase
  end

  // slots feed the tree directly; clearing them zero-pads the next group
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slots <= '0;
      r_idx   <= '0;
      r_count <= '0;
    end else if (w_issue) begin
      r_slots <= '0;
      r_idx   <= '0;
    end else if (w_accept) begin
      r_slots[r_idx] <= in_data;
      r_idx          <= r_idx + 1'b1;
      if (w_end)
        r_count <= CNT_W'(r_idx) + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_credits <= CRW'(DEPTH);
    else if (w_issue && !w_pop)
      r_credits <= r_credits - 1'b1;
    else if (w_pop && !w_issue)
      r_credits <= r_credits + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TREE_LAT; i++)
        r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '{valid: w_issue, count: r_count};
      for (int i = 1; i < TREE_LAT; i++)
        r_tag[i] <= r_tag[i-1];
    end
  end

  adder_tree u_tree (
    .clk     (clk),
    .in_ops  (r_slots),
    .sum_out (w_sum)
  );

  adder_tree_result_fifo #(
    .DEPTH (DEPTH),
    .W     (SUM_W + CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (r_tag[TREE_LAT-1].valid),
    .din   ({w_sum, r_tag[TREE_LAT-1].count}),
    .pop   (w_pop),
    .dout  ({out_sum, out_count}),
    .valid (out_valid)
  );
endmodule

// File: tb/tb_adder_tree_stream_feeder.sv
// Directed and random stimulus against a queue-based group/sum model.
// Also watches credit conservation and output stability under stall.
module tb_adder_tree_stream_feeder;
  import adder_tree_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic [3:0]  out_count;

  always #5 clk = ~clk;

  adder_tree_stream_feeder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
  );

  typedef struct {
    logic [31:0] sum;
    logic [3:0]  cnt;
  } res_t;

  res_t exp_q[$];
  int   cur[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   rise_cyc = 0;
  int   pops = 0;
  int   n_groups = 0;
  bit   acc_flag = 0;
  bit   prev_valid = 0;
  bit   prev_hold = 0;
  logic [31:0] prev_sum = '0;
  logic [3:0]  prev_cnt = '0;
  logic [31:0] last_sum = '0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // one clock: observe handshakes at negedge, then advance past posedge
  task automatic step();
    @(negedge clk);
    acc_flag = 0;
    if (reset) begin
      cur.delete();
      exp_q.delete();
      prev_hold = 0;
    end else begin
      if (out_valid && !prev_valid)
        rise_cyc = cyc;
      if (prev_hold && out_valid) begin
        check("hold_sum", 64'(out_sum), 64'(prev_sum));
        check("hold_count", 64'(out_count), 64'(prev_cnt));
      end
      if (in_valid && in_ready) begin
        acc_flag = 1;
        cur.push_back(int'(in_data));
        if (in_last || cur.size() == OPERANDS) begin
          int s;
          s = 0;
          foreach (cur[i]) s += cur[i];
          exp_q.push_back('{32'(s), 4'(cur.size())});
          cur.delete();
          acc_cyc = cyc + 1;
          n_groups++;
        end
      end
      if (out_valid && out_ready) begin
        pops++;
        last_sum = out_sum;
        if (exp_q.size() == 0) begin
          check("spurious_result", 64'(1), 64'(0));
        end else begin
          res_t r;
          r = exp_q.pop_front();
          check("sum", 64'(out_sum), 64'(r.sum));
          check("count", 64'(out_count), 64'(r.cnt));
        end
      end
      begin
        int tot;
        tot = int'(dut.r_credits) + int'(dut.u_fifo.r_count);
        for (int i = 0; i < TREE_LAT; i++)
          tot += int'(dut.r_tag[i].valid);
        check("credit_balance", 64'(tot), 64'(DEPTH));
      end
      prev_hold = out_valid && !out_ready;
      prev_sum  = out_sum;
      prev_cnt  = out_count;
    end
    prev_valid = out_valid;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic feed(input int d, input bit last);
    int t;
    in_valid = 1'b1;
    in_data  = 16'(d);
    in_last  = last;
    t = 0;
    do begin
      step();
      t++;
    end while (!acc_flag && t < 200);
    if (!acc_flag)
      check("feed_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 400) begin
      step();
      t++;
    end
    check("drain_left", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_sum", 64'(out_sum), 64'(0));
    check("rst_out_count", 64'(out_count), 64'(0));

    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) feed(i, i == 8);
    drain();
    check("latency", 64'(rise_cyc - acc_cyc), 64'(4));
    check("sum_1to8", 64'(last_sum), 64'(36));
    repeat (3) step();

    for (int i = 0; i < 8; i++) feed(16'hFFFF, 1'b0);
    drain();
    check("max_sum", 64'(last_sum), 64'h7FFF8);
    repeat (3) step();

    p0 = pops;
    feed(10, 1'b0);
    feed(20, 1'b0);
    feed(30, 1'b1);
    for (int i = 1; i <= 8; i++) feed(i, 1'b0);
    drain();
    check("short_then_full", 64'(pops - p0), 64'(2));
    repeat (3) step();

    out_ready = 1'b0;
    for (int g = 0; g < 5; g++)
      for (int k = 1; k <= 8; k++) feed(g * 100 + k, 1'b0);
    repeat (10) step();
    check("stall_in_ready", 64'(in_ready), 64'(0));
    check("stall_out_valid", 64'(out_valid), 64'(1));
    check("stall_queued", 64'(dut.u_fifo.r_count), 64'(DEPTH));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pre_issue_in_ready", 64'(in_ready), 64'(0));
    step();
    check("post_issue_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    drain();
    repeat (3) step();

    for (int i = 1; i <= 5; i++) feed(i * 7, 1'b0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    p0 = pops;
    for (int i = 1; i <= 8; i++) feed(i, 1'b0);
    drain();
    repeat (10) step();
    check("reset_one_result", 64'(pops - p0), 64'(1));
    check("reset_sum", 64'(last_sum), 64'(36));

    p0 = n_groups;
    while (n_groups - p0 < 1500 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 16'($urandom);
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    check("random_groups_done", 64'(n_groups - p0 >= 1500), 64'(1));
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    drain();
    repeat (5) step();
    check("final_idle", 64'(out_valid), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
